cbi980_regarb: RTL and testbench

Two-requester arbiter and sequencer for the cbi980_core register port.
- Lets the host bus front end (m0) and an autonomous sample/DMA engine (m1) share one core port.
- Sequences single-cycle writes and variable-latency reads, round-robin between requesters.
- Returns data and error status to the requester that owns the transaction.

---
 rtl/cbi980_regarb.sv | 176 +++++++++++++++++
 tb/tb_cbi980_regarb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbi980_regarb.sv
// Round-robin arbiter/sequencer sharing the cbi980_core register port between m0 (host) and m1 (DMA).
// Optional read watchdog is enabled by defining CBI980_ARB_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module cbi980_regarb #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [2:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_en,
  input  logic        wr_err,
  output logic [2:0]  rd_addr,
  output logic        rd_valid_in,
  input  logic [31:0] rd_data,
  input  logic        rd_valid_out,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

  state_t      r_state;
  logic        r_owner;
  logic [2:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic [2:0]  r_rd_addr;
  logic        r_wr_en;
  logic        r_rd_vld;
  logic        r_m0_done, r_m1_done;
  logic [31:0] r_m0_rdata, r_m1_rdata;
  logic        r_m0_err, r_m1_err;

  logic        w_any_req;
  logic        w_grant_m1;
  logic        w_sel_we;
  logic [2:0]  w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_fin;
  logic [31:0] w_fin_rdata;
  logic        w_fin_err;

`ifdef CBI980_ARB_TIMEOUT_EN
  localparam logic [15:0] LP_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // On a tie the requester that did not own the last transaction wins.
  assign w_any_req   = m0_req | m1_req;
  assign w_grant_m1  = m1_req & (~m0_req | ~r_owner);
  assign w_sel_we    = w_grant_m1 ? m1_we    : m0_we;
  assign w_sel_addr  = w_grant_m1 ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_grant_m1 ? m1_wdata : m0_wdata;

  always_comb begin
    w_fin       = 1'b0;
    w_fin_rdata = '0;
    w_fin_err   = 1'b0;
    case (r_state)
      S_WRITE: begin
        w_fin     = 1'b1;
        w_fin_err = wr_err;
      end
      S_READ: begin
        if (rd_valid_out) begin
          w_fin       = 1'b1;
          w_fin_rdata = rd_data;
        end
`ifdef CBI980_ARB_TIMEOUT_EN
        else if (r_cnt == LP_LIMIT) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b1;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_m0_done  <= 1'b0;
      r_m1_done  <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
`ifdef CBI980_ARB_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else begin
      r_m0_done <= 1'b0;
      r_m1_done <= 1'b0;
      r_wr_en   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner   <= w_grant_m1;
            r_wr_addr <= w_sel_addr;
            r_rd_addr <= w_sel_addr;
            r_wr_data <= w_sel_wdata;
            if (w_sel_we) begin
              r_state <= S_WRITE;
              r_wr_en <= 1'b1;
            end else begin
              r_state  <= S_READ;
              r_rd_vld <= 1'b1;
`ifdef CBI980_ARB_TIMEOUT_EN
              r_cnt    <= '0;
`endif
            end
          end
        end
        S_READ: begin
`ifdef CBI980_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 16'd1;
`endif
        end
        S_RESP:  r_state <= S_IDLE;
        default: ;
      endcase
      // Completion routes status to the owner only; the other side holds its last values.
      if (w_fin) begin
        r_state  <= S_RESP;
        r_rd_vld <= 1'b0;
        if (r_owner) begin
          r_m1_done  <= 1'b1;
          r_m1_rdata <= w_fin_rdata;
          r_m1_err   <= w_fin_err;
        end else begin
          r_m0_done  <= 1'b1;
          r_m0_rdata <= w_fin_rdata;
          r_m0_err   <= w_fin_err;
        end
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign owner       = r_owner;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign wr_en       = r_wr_en;
  assign rd_addr     = r_rd_addr;
  assign rd_valid_in = r_rd_vld;
  assign m0_done     = r_m0_done;
  assign m0_rdata    = r_m0_rdata;
  assign m0_err      = r_m0_err;
  assign m1_done     = r_m1_done;
  assign m1_rdata    = r_m1_rdata;
  assign m1_err      = r_m1_err;

endmodule

// File: tb/tb_cbi980_regarb.sv
// Bench for cbi980_regarb: directed scenarios plus a per-requester completion scoreboard.
module tb_cbi980_regarb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [2:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_done, m1_done, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [2:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic        wr_en, wr_err, rd_valid_in, rd_valid_out, busy, owner;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  cbi980_regarb #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_err(wr_err),
    .rd_addr(rd_addr), .rd_valid_in(rd_valid_in), .rd_data(rd_data),
    .rd_valid_out(rd_valid_out), .busy(busy), .owner(owner)
  );

  // Scoreboard: every done pulse must match the oldest expectation for that requester.
  always @(negedge clk) begin
    if (m0_done === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL sb_m0_unexpected_done rdata=%h err=%b required=no done", m0_rdata, m0_err);
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (m0_rdata !== e.rdata || m0_err !== e.err) begin
          failures++;
          $display("FAIL sb_m0 got rdata=%h err=%b required rdata=%h err=%b", m0_rdata, m0_err, e.rdata, e.err);
        end
      end
    end
    if (m1_done === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL sb_m1_unexpected_done rdata=%h err=%b required=no done", m1_rdata, m1_err);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (m1_rdata !== e.rdata || m1_err !== e.err) begin
          failures++;
          $display("FAIL sb_m1 got rdata=%h err=%b required rdata=%h err=%b", m1_rdata, m1_err, e.rdata, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    wr_err = 0; rd_data = 0; rd_valid_out = 0;
    do_reset();
    checks++;
    if (wr_en !== 0 || rd_valid_in !== 0 || wr_addr !== 0 || rd_addr !== 0 || wr_data !== 0) begin
      failures++;
      $display("FAIL reset_core wr_en=%b rd_vld=%b wa=%h ra=%h wd=%h required all 0", wr_en, rd_valid_in, wr_addr, rd_addr, wr_data);
    end
    checks++;
    if (m0_done !== 0 || m1_done !== 0 || m0_err !== 0 || m1_err !== 0 || m0_rdata !== 0 || m1_rdata !== 0) begin
      failures++;
      $display("FAIL reset_req_side d0=%b d1=%b e0=%b e1=%b r0=%h r1=%h required all 0", m0_done, m1_done, m0_err, m1_err, m0_rdata, m1_rdata);
    end
    checks++;
    if (busy !== 0 || owner !== 1) begin
      failures++;
      $display("FAIL reset_state busy=%b owner=%b required busy=0 owner=1", busy, owner);
    end
  endtask

  task automatic test_write_m0();
    tick();
    m0_we = 1; m0_addr = 3'd3; m0_wdata = 32'hDEADBEEF; m0_req = 1;
    q0.push_back('{rdata: 32'h0, err: 1'b0});
    tick();
    checks++;
    if (wr_en !== 1 || wr_addr !== 3'd3 || wr_data !== 32'hDEADBEEF || busy !== 1) begin
      failures++;
      $display("FAIL wr_m0_strobe wr_en=%b wa=%h wd=%h busy=%b required 1 3 deadbeef 1", wr_en, wr_addr, wr_data, busy);
    end
    m0_req = 0;
    tick();
    checks++;
    if (m0_done !== 1 || m1_done !== 0 || wr_en !== 0) begin
      failures++;
      $display("FAIL wr_m0_done d0=%b d1=%b wr_en=%b required 1 0 0", m0_done, m1_done, wr_en);
    end
    tick();
    checks++;
    if (busy !== 0 || m0_done !== 0) begin
      failures++;
      $display("FAIL wr_m0_idle busy=%b d0=%b required 0 0", busy, m0_done);
    end
  endtask

  task automatic test_write_m1_err();
    tick();
    m1_we = 1; m1_addr = 3'd5; m1_wdata = 32'hA5A5_0001; m1_req = 1;
    q1.push_back('{rdata: 32'h0, err: 1'b1});
    tick();
    checks++;
    if (wr_en !== 1 || wr_addr !== 3'd5 || owner !== 1) begin
      failures++;
      $display("FAIL wr_m1_strobe wr_en=%b wa=%h owner=%b required 1 5 1", wr_en, wr_addr, owner);
    end
    wr_err = 1; m1_req = 0;
    tick();
    wr_err = 0;
    checks++;
    if (m1_done !== 1 || m1_err !== 1 || m0_done !== 0 || m0_err !== 0) begin
      failures++;
      $display("FAIL wr_m1_done d1=%b e1=%b d0=%b e0=%b required 1 1 0 0", m1_done, m1_err, m0_done, m0_err);
    end
    tick();
    checks++;
    if (busy !== 0) begin
      failures++;
      $display("FAIL wr_m1_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_read_m0();
    // Stray completion while idle must be ignored.
    tick();
    rd_valid_out = 1; rd_data = 32'hFFFF_FFFF;
    tick();
    rd_valid_out = 0;
    checks++;
    if (busy !== 0 || rd_valid_in !== 0) begin
      failures++;
      $display("FAIL rd_stray busy=%b rd_vld=%b required 0 0", busy, rd_valid_in);
    end
    m0_we = 0; m0_addr = 3'd2; m0_req = 1;
    q0.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) m0_req = 0;
      checks++;
      if (rd_valid_in !== 1 || rd_addr !== 3'd2 || m0_done !== 0) begin
        failures++;
        $display("FAIL rd_wait c=%0d rd_vld=%b ra=%h d0=%b required 1 2 0", c, rd_valid_in, rd_addr, m0_done);
      end
      if (c == 4) begin
        rd_valid_out = 1; rd_data = 32'h1234_5678;
      end
    end
    tick();
    rd_valid_out = 0; rd_data = 0;
    checks++;
    if (rd_valid_in !== 0 || m0_done !== 1 || m0_rdata !== 32'h1234_5678 || m0_err !== 0) begin
      failures++;
      $display("FAIL rd_done rd_vld=%b d0=%b r0=%h e0=%b required 0 1 12345678 0", rd_valid_in, m0_done, m0_rdata, m0_err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic        exp_m1;
    logic [2:0]  exp_addr;
    logic [31:0] exp_data;
    do_reset();
    m0_we = 1; m0_addr = 3'd1; m0_wdata = 32'h0000_AAAA;
    m1_we = 1; m1_addr = 3'd6; m1_wdata = 32'h0000_BBBB;
    m0_req = 1; m1_req = 1;
    for (int k = 0; k < 2; k++) begin
      q0.push_back('{rdata: 32'h0, err: 1'b0});
      q1.push_back('{rdata: 32'h0, err: 1'b0});
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      if ((c - 1) % 3 == 0 && c < 12) begin
        exp_m1   = (((c - 1) / 3) % 2) == 1;
        exp_addr = exp_m1 ? 3'd6 : 3'd1;
        exp_data = exp_m1 ? 32'h0000_BBBB : 32'h0000_AAAA;
        checks++;
        if (wr_en !== 1 || wr_addr !== exp_addr || wr_data !== exp_data || owner !== exp_m1) begin
          failures++;
          $display("FAIL b2b_grant c=%0d wr_en=%b wa=%h wd=%h owner=%b required 1 %h %h %b", c, wr_en, wr_addr, wr_data, owner, exp_addr, exp_data, exp_m1);
        end
      end else begin
        checks++;
        if (wr_en !== 0) begin
          failures++;
          $display("FAIL b2b_gap c=%0d wr_en=%b required 0", c, wr_en);
        end
      end
      if (c == 11) begin
        m0_req = 0; m1_req = 0;
      end
    end
    tick();
    checks++;
    if (busy !== 0) begin
      failures++;
      $display("FAIL b2b_end busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    m1_we = 0; m1_addr = 3'd4; m1_req = 1;
    tick();
    m1_req = 0;
    checks++;
    if (rd_valid_in !== 1 || rd_addr !== 3'd4) begin
      failures++;
      $display("FAIL rstmid_issue rd_vld=%b ra=%h required 1 4", rd_valid_in, rd_addr);
    end
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    rd_valid_out = 1; rd_data = 32'hCAFE_F00D;
    checks++;
    if (busy !== 0 || rd_valid_in !== 0 || wr_en !== 0 || owner !== 1 || m1_done !== 0 ||
        m1_rdata !== 0 || m0_rdata !== 0 || m1_err !== 0 || rd_addr !== 0 || wr_addr !== 0 || wr_data !== 0) begin
      failures++;
      $display("FAIL rstmid_state busy=%b rd_vld=%b owner=%b d1=%b r1=%h ra=%h required 0 0 1 0 0 0", busy, rd_valid_in, owner, m1_done, m1_rdata, rd_addr);
    end
    tick();
    rd_valid_out = 0; rd_data = 0;
    checks++;
    if (busy !== 0 || m1_done !== 0 || m1_rdata !== 0) begin
      failures++;
      $display("FAIL rstmid_late busy=%b d1=%b r1=%h required 0 0 0", busy, m1_done, m1_rdata);
    end
    tick();
  endtask

`ifdef CBI980_ARB_TIMEOUT_EN
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      tick();
      m0_we = 0; m0_addr = 3'd7; m0_req = 1;
      if (pass == 0) q0.push_back('{rdata: 32'h0, err: 1'b1});
      else           q0.push_back('{rdata: 32'h0BAD_CAFE, err: 1'b0});
      for (int c = 1; c <= 8; c++) begin
        tick();
        if (c == 1) m0_req = 0;
        checks++;
        if (rd_valid_in !== 1) begin
          failures++;
          $display("FAIL tmo_wait pass=%0d c=%0d rd_vld=%b required 1", pass, c, rd_valid_in);
        end
        if (c == 8 && pass == 1) begin
          rd_valid_out = 1; rd_data = 32'h0BAD_CAFE;
        end
      end
      tick();
      rd_valid_out = 0; rd_data = 0;
      checks++;
      if (rd_valid_in !== 0 || m0_done !== 1) begin
        failures++;
        $display("FAIL tmo_done pass=%0d rd_vld=%b d0=%b required 0 1", pass, rd_valid_in, m0_done);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_m0();
    test_write_m1_err();
    test_read_m0();
    test_back_to_back();
    test_reset_mid();
`ifdef CBI980_ARB_TIMEOUT_EN
    test_timeout();
`endif
    tick();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL sb_drain pending_m0=%0d pending_m1=%0d required 0 0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
